kbd_key_state: RTL

- Translates the PS/2 scancode byte stream into held-key levels for the player controller: key_space, key_left, key_right.
- Sits between the PS/2 byte receiver (one-cycle byte strobe) and the character movement FSM.
- Decodes Set-2 make/break sequences, including the 0xE0 extended and 0xF0 break prefixes.
- A prefix timeout recovers from truncated sequences.

---
 rtl/kbd_pkg.sv | 23 ++
 rtl/kbd_key_state_if.sv | 19 +
 rtl/kbd_key_state.sv | 105 ++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared types and Set-2 scancode constants for the keyboard key-state decoder.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_OVR0  = 8'h00;
  localparam logic [7:0] SC_OVR1  = 8'hFF;

  function automatic logic is_overrun(input logic [7:0] code);
    return (code == SC_OVR0) || (code == SC_OVR1);
  endfunction

endpackage

// File: rtl/kbd_key_state_if.sv
// Byte stream from the PS/2 receiver in, held-key levels out to the movement FSM.
interface kbd_key_state_if;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       key_space;
  logic       key_left;
  logic       key_right;
  logic       seq_error;

  modport master (
    output scancode, scancode_valid,
    input  key_space, key_left, key_right, seq_error
  );

  modport slave (
    input  scancode, scancode_valid,
    output key_space, key_left, key_right, seq_error
  );
endinterface

// File: rtl/kbd_key_state.sv
// Set-2 make/break decoder producing held levels for space, left and right arrows,
// with a prefix timeout that abandons truncated E0/F0 sequences.
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | no prefix pending
// EXT     | got E0, waiting for extended code or F0
// BRK     | got F0, next byte is a normal break code
// EXT_BRK | got E0 F0, next byte is an extended break
module kbd_key_state
  import kbd_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 1_000_000,
  parameter int CNT_W          = 20
) (
  input logic             clk,
  input logic             rst,
  kbd_key_state_if.slave  kbd
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  kbd_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             space_q, left_q, right_q, err_q;
  logic             space_nxt, left_nxt, right_nxt, err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      space_q <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      space_q <= space_nxt;
      left_q  <= left_nxt;
      right_q <= right_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    space_nxt = space_q;
    left_nxt  = left_q;
    right_nxt = right_q;
    err_nxt   = 1'b0;

    if (kbd.scancode_valid) begin
      // A strobe always restarts the prefix window, even on the limit cycle.
      cnt_nxt = '0;
      if (is_overrun(kbd.scancode)) begin
        space_nxt = 1'b0;
        left_nxt  = 1'b0;
        right_nxt = 1'b0;
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (kbd.scancode == SC_EXT)        state_nxt = EXT;
            else if (kbd.scancode == SC_BRK)   state_nxt = BRK;
            else if (kbd.scancode == SC_SPACE) space_nxt = 1'b1;
          end
          EXT: begin
            state_nxt = IDLE;
            if (kbd.scancode == SC_BRK)        state_nxt = EXT_BRK;
            else if (kbd.scancode == SC_EXT)   state_nxt = EXT;
            else if (kbd.scancode == SC_LEFT)  left_nxt  = 1'b1;
            else if (kbd.scancode == SC_RIGHT) right_nxt = 1'b1;
          end
          BRK: begin
            state_nxt = IDLE;
            if (kbd.scancode == SC_SPACE) space_nxt = 1'b0;
          end
          EXT_BRK: begin
            state_nxt = IDLE;
            if (kbd.scancode == SC_LEFT)       left_nxt  = 1'b0;
            else if (kbd.scancode == SC_RIGHT) right_nxt = 1'b0;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (state != IDLE) begin
      if (cnt == CNT_LAST) begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  assign kbd.key_space = space_q;
  assign kbd.key_left  = left_q;
  assign kbd.key_right = right_q;
  assign kbd.seq_error = err_q;

endmodule
